// File: rtl/dot_cascade_n.sv
// Signed dot-product engine: y = bias + sum(a_i*b_i) built as a systolic partial-sum cascade,
// with valid/last tagging, global clock-enable stall, optional group accumulation and wrap/saturate output.
module dot_cascade_n #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 4,
  parameter int OUT_WIDTH = 8,
  parameter int ACC_WIDTH = 48,
  parameter int SATURATE  = 0,
  parameter int ACCUM     = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic signed [WIDTH-1:0]     bias,
  input  logic [LANES*WIDTH-1:0]      a,
  input  logic [LANES*WIDTH-1:0]      b,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] y
);
  localparam int PW  = 2 * WIDTH;
  localparam int CTL = LANES + 2;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic                        first_in_reg;
  logic signed [WIDTH-1:0]     bias_ab_reg;
  logic signed [WIDTH-1:0]     bias_m_reg;
  logic [CTL-1:0]              vld_reg;
  logic [CTL-1:0]              lst_reg;
  logic [CTL-1:0]              fst_reg;
  logic signed [ACC_WIDTH-1:0] acc_reg;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [ACC_WIDTH-1:0] p_fin;

  // Control tags ride alongside the data so the tail sees the beat's own valid/last/first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      first_in_reg <= 1'b1;
      bias_ab_reg  <= '0;
      bias_m_reg   <= '0;
      vld_reg      <= '0;
      lst_reg      <= '0;
      fst_reg      <= '0;
    end else if (en) begin
      vld_reg     <= {vld_reg[CTL-2:0], in_valid};
      lst_reg     <= {lst_reg[CTL-2:0], in_valid & in_last};
      fst_reg     <= {fst_reg[CTL-2:0], first_in_reg};
      bias_ab_reg <= (ACCUM == 0 || first_in_reg) ? bias : '0;
      bias_m_reg  <= bias_ab_reg;
      if (in_valid)
        first_in_reg <= (ACCUM == 0) ? 1'b1 : in_last;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [WIDTH-1:0]     a_pipe [gi+1];
    logic signed [WIDTH-1:0]     b_pipe [gi+1];
    logic signed [PW-1:0]        m_reg;
    logic signed [ACC_WIDTH-1:0] m_ext;
    logic signed [ACC_WIDTH-1:0] p_in;
    logic signed [ACC_WIDTH-1:0] p_reg;

    assign m_ext = {{(ACC_WIDTH-PW){m_reg[PW-1]}}, m_reg};

    if (gi == 0) begin : g_head
      assign p_in = {{(ACC_WIDTH-WIDTH){bias_m_reg[WIDTH-1]}}, bias_m_reg};
    end else begin : g_link
      assign p_in = g_lane[gi-1].p_reg;
    end

    // Lane gi is skewed by gi cycles so its product meets the partial sum from lane gi-1.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int k = 0; k <= gi; k++) begin
          a_pipe[k] <= '0;
          b_pipe[k] <= '0;
        end
        m_reg <= '0;
        p_reg <= '0;
      end else if (en) begin
        a_pipe[0] <= a[gi*WIDTH +: WIDTH];
        b_pipe[0] <= b[gi*WIDTH +: WIDTH];
        for (int k = 1; k <= gi; k++) begin
          a_pipe[k] <= a_pipe[k-1];
          b_pipe[k] <= b_pipe[k-1];
        end
        m_reg <= PW'(a_pipe[gi]) * PW'(b_pipe[gi]);
        p_reg <= p_in + m_ext;
      end
    end
  end

  assign p_fin    = g_lane[LANES-1].p_reg;
  assign acc_next = (fst_reg[CTL-1] ? '0 : acc_reg) + p_fin;

  function automatic logic signed [OUT_WIDTH-1:0] fmt(input logic signed [ACC_WIDTH-1:0] v);
    if (SATURATE != 0 && v > SAT_MAX) return {1'b0, {(OUT_WIDTH-1){1'b1}}};
    if (SATURATE != 0 && v < SAT_MIN) return {1'b1, {(OUT_WIDTH-1){1'b0}}};
    return v[OUT_WIDTH-1:0];
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_reg   <= '0;
      out_valid <= 1'b0;
      y         <= '0;
    end else if (en) begin
      out_valid <= 1'b0;
      if (vld_reg[CTL-1]) begin
        if (ACCUM == 0) begin
          y         <= fmt(p_fin);
          out_valid <= 1'b1;
        end else begin
          acc_reg <= acc_next;
          if (lst_reg[CTL-1]) begin
            y         <= fmt(acc_next);
            out_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_cascade_n.sv
// Bench for dot_cascade_n: four configurations (wrap/saturate x single/accumulate) share one
// stimulus stream and are compared every cycle against an arithmetic result-queue model.
module tb_dot_cascade_n;
  localparam int LANES = 4;
  localparam int NI    = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              en;
  logic              in_valid;
  logic              in_last;
  logic signed [7:0] bias;
  logic [31:0]       a;
  logic [31:0]       b;
  logic              ov [NI];
  logic signed [7:0] yv [NI];

  always #5 clock = ~clock;

  dot_cascade_n #(.WIDTH(8), .LANES(LANES), .OUT_WIDTH(8), .ACC_WIDTH(48), .SATURATE(0), .ACCUM(0)) u_wrap (
    .clock(clock), .reset(reset), .en(en), .in_valid(in_valid), .in_last(in_last),
    .bias(bias), .a(a), .b(b), .out_valid(ov[0]), .y(yv[0]));
  dot_cascade_n #(.WIDTH(8), .LANES(LANES), .OUT_WIDTH(8), .ACC_WIDTH(48), .SATURATE(1), .ACCUM(0)) u_sat (
    .clock(clock), .reset(reset), .en(en), .in_valid(in_valid), .in_last(in_last),
    .bias(bias), .a(a), .b(b), .out_valid(ov[1]), .y(yv[1]));
  dot_cascade_n #(.WIDTH(8), .LANES(LANES), .OUT_WIDTH(8), .ACC_WIDTH(48), .SATURATE(0), .ACCUM(1)) u_acc (
    .clock(clock), .reset(reset), .en(en), .in_valid(in_valid), .in_last(in_last),
    .bias(bias), .a(a), .b(b), .out_valid(ov[2]), .y(yv[2]));
  dot_cascade_n #(.WIDTH(8), .LANES(LANES), .OUT_WIDTH(8), .ACC_WIDTH(48), .SATURATE(1), .ACCUM(1)) u_accs (
    .clock(clock), .reset(reset), .en(en), .in_valid(in_valid), .in_last(in_last),
    .bias(bias), .a(a), .b(b), .out_valid(ov[3]), .y(yv[3]));

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  longint n = 0;
  longint d;
  longint s;
  longint exp_q [NI][$];
  longint due_q [NI][$];
  longint acc_m [NI] = '{default: 0};
  bit     first_m [NI] = '{default: 1'b1};
  longint last_y [NI] = '{default: 0};
  bit     ev;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint fmt_m(input longint v, input bit sat);
    longint w;
    if (sat) return (v > 127) ? 127 : ((v < -128) ? -128 : v);
    w = v & 255;
    return (w > 127) ? w - 256 : w;
  endfunction

  function automatic longint dot_now();
    longint acc;
    acc = 0;
    for (int i = 0; i < LANES; i++)
      acc += longint'($signed(a[i*8 +: 8])) * longint'($signed(b[i*8 +: 8]));
    return acc;
  endfunction

  function automatic logic [31:0] pack4(input int x0, input int x1, input int x2, input int x3);
    return {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
  endfunction

  always @(posedge clock) cyc++;

  // Model: each accepted beat yields an expected result due LANES+2 enabled edges later.
  always @(posedge clock) begin
    if (!reset && en) begin
      n++;
      if (in_valid) begin
        d = dot_now();
        for (int k = 0; k < NI; k++) begin
          if (k < 2) begin
            exp_q[k].push_back(fmt_m(d + longint'(bias), k == 1));
            due_q[k].push_back(n + LANES + 2);
          end else begin
            s = d + (first_m[k] ? longint'(bias) : 0);
            acc_m[k] = (first_m[k] ? 0 : acc_m[k]) + s;
            if (in_last) begin
              exp_q[k].push_back(fmt_m(acc_m[k], k == 3));
              due_q[k].push_back(n + LANES + 2);
              first_m[k] = 1'b1;
            end else begin
              first_m[k] = 1'b0;
            end
          end
        end
      end
    end
  end

  always @(posedge reset) begin
    for (int k = 0; k < NI; k++) begin
      exp_q[k].delete();
      due_q[k].delete();
      acc_m[k] = 0;
      first_m[k] = 1'b1;
      last_y[k] = 0;
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < NI; k++) begin
      while (due_q[k].size() > 0 && due_q[k][0] < n) begin
        void'(due_q[k].pop_front());
        void'(exp_q[k].pop_front());
      end
      ev = due_q[k].size() > 0 && due_q[k][0] == n;
      if (ev) last_y[k] = exp_q[k][0];
      check($sformatf("out_valid inst%0d cyc%0d", k, cyc), ov[k], ev);
      check($sformatf("y inst%0d cyc%0d", k, cyc), yv[k], last_y[k]);
    end
  end

  task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic signed [7:0] bs,
                       input logic lst, input logic vld);
    @(posedge clock);
    #1;
    a = av; b = bv; bias = bs; in_last = lst; in_valid = vld;
  endtask

  task automatic idle();
    drive(32'd0, 32'd0, 8'sd0, 1'b0, 1'b0);
  endtask

  task automatic wait_pulse(input int k, input int c0, output int lat, output longint val);
    lat = -1;
    val = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clock);
      if (ov[k] === 1'b1) begin
        lat = cyc - c0;
        val = longint'(yv[k]);
        return;
      end
    end
  endtask

  int     c0;
  int     lat;
  longint val;
  int     nb;
  logic   v;

  initial begin
    reset = 1'b1; en = 1'b1; in_valid = 1'b0; in_last = 1'b0; bias = '0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset out_valid inst%0d", k), ov[k], 0);
      check($sformatf("reset y inst%0d", k), yv[k], 0);
    end
    reset = 1'b0;

    // Single beat: 1*5+2*6+3*7+4*8+10 = 80, visible 7 cycles later.
    drive(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 8'sd10, 1'b1, 1'b1);
    c0 = cyc;
    idle();
    wait_pulse(0, c0, lat, val);
    check("basic latency", lat, 7);
    check("basic y wrap", val, 80);
    check("basic y accum", yv[2], 80);

    // Saturation: 4*(-128*-128)=65536 and 4*(-128*127)=-65024.
    drive(pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), 8'sd0, 1'b1, 1'b1);
    c0 = cyc;
    idle();
    wait_pulse(0, c0, lat, val);
    check("sat+ wrap", val, 0);
    check("sat+ clamp", yv[1], 127);
    check("sat+ clamp accum", yv[3], 127);
    drive(pack4(-128, -128, -128, -128), pack4(127, 127, 127, 127), 8'sd0, 1'b1, 1'b1);
    c0 = cyc;
    idle();
    wait_pulse(0, c0, lat, val);
    check("sat- wrap", val, 0);
    check("sat- clamp", yv[1], -128);

    // Accumulation: group {10,20,-5}+bias 2 = 27, then back-to-back group {7} = 7.
    drive(pack4(10, 0, 0, 0), pack4(1, 0, 0, 0), 8'sd2, 1'b0, 1'b1);
    c0 = cyc;
    drive(pack4(20, 0, 0, 0), pack4(1, 0, 0, 0), 8'sd0, 1'b0, 1'b1);
    drive(pack4(-5, 0, 0, 0), pack4(1, 0, 0, 0), 8'sd0, 1'b1, 1'b1);
    drive(pack4(7, 0, 0, 0), pack4(1, 0, 0, 0), 8'sd0, 1'b1, 1'b1);
    idle();
    wait_pulse(2, c0, lat, val);
    check("accum group1 y", val, 27);
    check("accum group1 latency", lat, 9);
    wait_pulse(2, c0, lat, val);
    check("accum group2 y", val, 7);
    check("accum group2 latency", lat, 10);

    // Stall: three beats in flight, en low for three cycles.
    drive(pack4(1, 1, 1, 1), pack4(1, 2, 3, 4), 8'sd0, 1'b1, 1'b1);
    c0 = cyc;
    drive(pack4(2, 0, 0, 3), pack4(5, 0, 0, -1), 8'sd1, 1'b1, 1'b1);
    drive(pack4(-3, 4, 0, 0), pack4(2, 2, 0, 0), 8'sd0, 1'b1, 1'b1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    en = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    en = 1'b1;
    wait_pulse(0, c0, lat, val);
    check("stall latency", lat, 10);
    check("stall y", val, 10);
    repeat (8) idle();

    // Streaming: 20 random beats with random bubbles.
    nb = 0;
    while (nb < 20) begin
      v = ($urandom_range(0, 3) != 0);
      drive($urandom(), $urandom(), 8'($urandom()), ($urandom_range(0, 2) == 0), v);
      if (v) nb++;
    end
    // Random stalls mixed with random traffic.
    for (int t = 0; t < 40; t++) begin
      @(posedge clock);
      #1;
      en = ($urandom_range(0, 4) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_last = ($urandom_range(0, 2) == 0);
      a = $urandom();
      b = $urandom();
      bias = 8'($urandom());
    end
    @(posedge clock);
    #1;
    en = 1'b1;
    in_valid = 1'b0;
    repeat (12) idle();

    // Reset mid-stream: accumulator holds 40 with five beats in flight.
    drive(32'd0, 32'd0, 8'sd0, 1'b1, 1'b1);
    drive(pack4(40, 0, 0, 0), pack4(1, 0, 0, 0), 8'sd0, 1'b0, 1'b1);
    repeat (9) idle();
    for (int t = 0; t < 5; t++)
      drive(pack4(t + 1, 2, 0, 0), pack4(3, t, 0, 0), 8'sd0, 1'b0, 1'b1);
    @(posedge clock);
    #3;
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("async reset out_valid inst%0d", k), ov[k], 0);
      check($sformatf("async reset y inst%0d", k), yv[k], 0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive(pack4(7, 0, 0, 0), pack4(1, 0, 0, 0), 8'sd0, 1'b1, 1'b1);
    c0 = cyc;
    idle();
    wait_pulse(2, c0, lat, val);
    check("post-reset accum y", val, 7);
    check("post-reset latency", lat, 7);
    repeat (10) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dot_cascade_n.md
Name: dot_cascade_n

Overview:
- Parametrised signed dot-product engine: y = bias + sum over lanes i of a_i*b_i.
- LANES multiply lanes are chained as a systolic cascade, where each lane adds its product to the partial sum from the previous lane. This matches the DSP-cascade mapping.
- Adds a valid/last handshake, a global clock-enable stall, an optional multi-beat accumulation mode, and a selectable wrap/saturate output.
- Sits between operand buffers and the activation stage in the compute datapath.

Parameters:
- WIDTH, 8: signed width of each a/b operand and of bias.
- LANES, 4: number of multiply lanes; legal range 1..16.
- OUT_WIDTH, 8: signed width of y.
- ACC_WIDTH, 48: internal partial-sum and accumulator width; must be >= 2*WIDTH+clog2(LANES)+8.
- SATURATE, 0: 0 = wrap (truncate low OUT_WIDTH bits); 1 = clamp to signed OUT_WIDTH range.
- ACCUM, 0: 0 = one result per input beat; 1 = accumulate beats until in_last.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- en  in  1  global clock enable; low freezes every register including valid/last/accumulator.
- in_valid  in  1  input beat valid.
- in_last  in  1  final beat of an accumulation group; ignored when ACCUM=0.
- bias  in  WIDTH  signed bias, sampled with the beat; used only on the group's first beat when ACCUM=1.
- a  in  LANES*WIDTH  packed signed operands; lane i = a[i*WIDTH +: WIDTH].
- b  in  LANES*WIDTH  packed signed operands, same packing.
- out_valid  out  1  y valid, one-cycle pulse per result.
- y  out  OUT_WIDTH  signed result.

Behaviour:
- Reset (async assert, any time): all pipeline data, valid and last regs, the accumulator and the first-beat flag go to 0/idle; first flag = 1; y = 0; out_valid = 0. In-flight beats are discarded. The first edge after deassert with en=1 operates normally.
- Pipeline, counted in en-high cycles:
  - Lane i inputs pass through i skew registers, then the A/B register, then the M register (full-precision product, 2*WIDTH, sign-extended to ACC_WIDTH).
  - The P chain: P0 = M0 + sext(bias); Pi = P(i-1) + Mi.
  - The final stage P(LANES-1) feeds the output stage.
- Latency: a beat sampled at cycle 0 produces out_valid at cycle LANES+3 (7 for LANES=4). Throughput is one beat per cycle. in_valid gaps propagate as bubbles.
- Data registers load only when en=1. Their contents are don't-care when the accompanying valid is 0, but must not produce X on y.
- en=0: pipeline, accumulator and outputs hold. out_valid stays as-is (a held pulse is consumed only once en returns). Results are never dropped or duplicated.
- Output stage (registered):
  - ACCUM=0: on tail valid, y = fmt(P_final) and out_valid=1; otherwise out_valid=0 and y holds its last value.
  - ACCUM=1: on tail valid, acc <= (first ? 0 : acc) + P_final, where bias was already injected into P_final only if the beat was first; bias is zeroed in the P0 addition for non-first beats.
  - ACCUM=1, tail last=1: y = fmt(new acc), out_valid=1, first <= 1.
  - ACCUM=1, tail last=0: out_valid=0, first <= 0.
  - The first flag is tracked at pipeline input (tagged per beat) so bias selection is correct for back-to-back groups.
- fmt:
  - Wrap: low OUT_WIDTH bits.
  - Saturate: values > 2^(OUT_WIDTH-1)-1 → max; values < -2^(OUT_WIDTH-1) → min.
- ACC_WIDTH overflow wraps silently; this is excluded by the parameter rule.
- in_last with in_valid=0 is ignored.
- Back-to-back groups: a last beat followed directly by a new first beat yields a correct, independent result.

Test Plan:
- LANES=4, WIDTH=8, wrap. a={1,2,3,4}, b={5,6,7,8}, bias=10, single beat → out_valid at cycle 7, y=80; out_valid low on all other cycles.
- Saturation. All a=-128, all b=-128, bias=0 → sum 65536; SATURATE=1 gives y=127, SATURATE=0 gives y=0. Repeat with a=-128, b=127 (sum -65024): saturate gives -128.
- Streaming. 20 consecutive random beats with in_valid bubbles → 20 out_valid pulses in order, each matching the reference model; bubbles are preserved.
- Stall. en low for 3 cycles while 3 beats are in flight → outputs delayed exactly 3 cycles, values intact, no duplicate pulses.
- ACCUM=1. Group of 3 beats with sums 10, 20, -5 and bias 2 on the first beat, then a 1-beat group with sum 7 and bias 0 → exactly two pulses, y=27 then y=7.
- Reset. Assert reset asynchronously mid-stream with 5 beats in flight and an accumulator holding 40 → y=0 and out_valid=0 immediately; no stale pulses after deassert; the next group accumulates from 0.
